// File: rtl/exc_pkg.sv
// exc_pkg: shared types and select constants for the exception sequencer.
package exc_pkg;
    typedef enum logic [1:0] {IDLE, SAVE_EPC, VEC_RD, PC_LD} exc_state_t;
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OPC = 2'b01;
    localparam logic [1:0] CAUSE_OVF = 2'b10;
    localparam logic [1:0] CAUSE_DIV0 = 2'b11;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] PCSRC_MEMEXT = 2'b11;
    function automatic logic [1:0] prio_cause(logic opc, logic ovf, logic div0);
        return opc ? CAUSE_OPC : ovf ? CAUSE_OVF : div0 ? CAUSE_DIV0 : CAUSE_NONE;
    endfunction
endpackage

// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: exception requests in, datapath overrides out.
interface exc_sequencer_if;
    logic req_opcode, req_ovf, req_div0;
    logic busy, epc_write, alu_ovr, alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_op;
    logic addr_ovr;
    logic [31:0] vec_addr;
    logic pc_load;
    logic [1:0] pc_src, cause;
    modport master(
        input req_opcode, req_ovf, req_div0,
        output busy, epc_write, alu_ovr, alu_srca, alu_srcb, alu_op,
        output addr_ovr, vec_addr, pc_load, pc_src, cause
    );
    modport slave(
        output req_opcode, req_ovf, req_div0,
        input busy, epc_write, alu_ovr, alu_srca, alu_srcb, alu_op,
        input addr_ovr, vec_addr, pc_load, pc_src, cause
    );
endinterface

// File: rtl/exc_sequencer.sv
// exc_sequencer: takes over the multicycle datapath to save EPC, fetch the
// handler byte from the vector table and load it into PC.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF = 32'd254,
    parameter logic [31:0] VEC_DIV0 = 32'd255
) (
    input logic clock,
    input logic reset_l,
    exc_sequencer_if.master bus
);
    exc_state_t state_q, state_d;
    logic [1:0] cause_q, cause_d, cnt_q, cnt_d;
    logic save, vec;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (bus.req_opcode || bus.req_ovf || bus.req_div0) begin
                cause_d = prio_cause(bus.req_opcode, bus.req_ovf, bus.req_div0);
                state_d = SAVE_EPC;
            end
            SAVE_EPC: begin
                state_d = VEC_RD;
                cnt_d = 2'(MEM_LAT - 1);
            end
            VEC_RD: begin
                state_d = cnt_q == 2'd0 ? PC_LD : VEC_RD;
                cnt_d = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
            end
            PC_LD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears them asynchronously.
    assign save = state_q == SAVE_EPC;
    assign vec = state_q == VEC_RD || state_q == PC_LD;
    assign bus.busy = state_q != IDLE;
    assign bus.epc_write = save;
    assign bus.alu_ovr = save;
    assign bus.alu_srca = 1'b0;
    assign bus.alu_srcb = save ? SRCB_FOUR : 2'b00;
    assign bus.alu_op = save ? ULA_SUB : 3'b000;
    assign bus.addr_ovr = vec;
    assign bus.vec_addr = !vec ? 32'd0 : cause_q == CAUSE_OPC ? VEC_OPCODE :
                          cause_q == CAUSE_OVF ? VEC_OVF : VEC_DIV0;
    assign bus.pc_load = state_q == PC_LD;
    assign bus.pc_src = state_q == PC_LD ? PCSRC_MEMEXT : 2'b00;
    assign bus.cause = cause_q;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: two sequencers (MEM_LAT 1 and 3) driven by the same
// requests, checked every cycle against a phase-count reference model.
module tb_exc_sequencer;
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic [31:0] pc = 32'h40;
    int total = 0;
    int bad = 0;
    int ph[2] = '{0, 0};
    logic [1:0] mc[2] = '{2'b00, 2'b00};
    int lat[2] = '{1, 3};

    exc_sequencer_if ifa();
    exc_sequencer_if ifb();

    exc_sequencer #(.MEM_LAT(1)) dut_a (.clock(clk), .reset_l(reset_l), .bus(ifa.master));
    exc_sequencer #(.MEM_LAT(3)) dut_b (.clock(clk), .reset_l(reset_l), .bus(ifb.master));

    always #5 clk = ~clk;

    wire [46:0] out_a = {ifa.busy, ifa.epc_write, ifa.alu_ovr, ifa.alu_srca, ifa.alu_srcb,
                         ifa.alu_op, ifa.addr_ovr, ifa.vec_addr, ifa.pc_load, ifa.pc_src, ifa.cause};
    wire [46:0] out_b = {ifb.busy, ifb.epc_write, ifb.alu_ovr, ifb.alu_srca, ifb.alu_srcb,
                         ifb.alu_op, ifb.addr_ovr, ifb.vec_addr, ifb.pc_load, ifb.pc_src, ifb.cause};

    // Datapath ALU as seen by the EPC register while the sequencer overrides it.
    wire [31:0] alu_a_in = ifa.alu_srca ? 32'd0 : pc;
    wire [31:0] alu_b_in = ifa.alu_srcb == 2'b01 ? 32'd4 : 32'd0;
    wire [31:0] alu_a = ifa.alu_op == 3'b010 ? alu_a_in - alu_b_in : alu_a_in + alu_b_in;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ph = cycles into the current sequence (0 = idle), last phase is lat+2.
    function automatic logic [46:0] expect_outs(int p, int l, logic [1:0] c);
        logic s = p == 1;
        logic v = p >= 2;
        logic ld = p == l + 2;
        return {p != 0, s, s, 1'b0, s ? 2'b01 : 2'b00, s ? 3'b010 : 3'b000, v,
                v ? 32'(252 + int'(c)) : 32'd0, ld, ld ? 2'b11 : 2'b00, c};
    endfunction

    task automatic set_req(logic o, logic v, logic d);
        ifa.req_opcode = o; ifa.req_ovf = v; ifa.req_div0 = d;
        ifb.req_opcode = o; ifb.req_ovf = v; ifb.req_div0 = d;
    endtask

    task automatic compare_all();
        check("outs_a", out_a, expect_outs(ph[0], lat[0], mc[0]));
        check("outs_b", out_b, expect_outs(ph[1], lat[1], mc[1]));
        if (ph[0] == 1) check("alu_epc", alu_a, pc - 32'd4);
    endtask

    task automatic tick();
        logic o = ifa.req_opcode;
        logic v = ifa.req_ovf;
        logic d = ifa.req_div0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (ph[i] == 0) begin
                if (o || v || d) begin
                    mc[i] = o ? 2'b01 : v ? 2'b10 : 2'b11;
                    ph[i] = 1;
                end
            end else begin
                ph[i] = ph[i] == lat[i] + 2 ? 0 : ph[i] + 1;
            end
        end
        #1 compare_all();
    endtask

    task automatic do_reset();
        #2 reset_l = 1'b0;
        #1 ph = '{0, 0};
        mc = '{2'b00, 2'b00};
        compare_all();
        @(posedge clk);
        #1 compare_all();
        reset_l = 1'b1;
    endtask

    initial begin
        set_req(0, 0, 0);
        #1 compare_all();
        @(posedge clk);
        #1 reset_l = 1'b1;
        set_req(0, 1, 0);
        tick();
        set_req(0, 0, 0);
        repeat (6) tick();
        set_req(1, 1, 1);
        tick();
        set_req(0, 0, 0);
        repeat (6) tick();
        set_req(1, 0, 0);
        tick();
        set_req(0, 0, 1);
        tick();
        set_req(0, 0, 0);
        repeat (6) tick();
        set_req(1, 0, 0);
        repeat (12) tick();
        set_req(0, 0, 0);
        repeat (6) tick();
        set_req(0, 0, 1);
        tick();
        set_req(0, 0, 0);
        tick();
        do_reset();
        set_req(0, 1, 0);
        tick();
        set_req(0, 0, 0);
        repeat (6) tick();
        repeat (1500) begin
            set_req($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
            if (ph[0] == 0) pc = $urandom & 32'hffff_fffc;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception sequencer for the multicycle MIPS datapath. It takes over the datapath when one of three exception requests arrives (invalid opcode, ALU overflow, divide-by-zero) and runs the full exception entry sequence:
- saves PC−4 into EPC through the ALU,
- reads the handler byte from the vector table in memory,
- loads the zero-extended byte into PC.

While it runs, it holds the main control unit with `busy` and overrides the IorD, ALUSrcA/B, ULAOp and PCSource selects.

## Interface

Parameters:
- `MEM_LAT`, default 1: memory read latency in cycles from address to valid `Dataout`; range 1–3.
- `VEC_OPCODE`, default 32'd253: vector table address for invalid opcode.
- `VEC_OVF`, default 32'd254: vector table address for overflow.
- `VEC_DIV0`, default 32'd255: vector table address for divide-by-zero.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset_l`, in, 1: reset, asynchronous and active-low.
- `req_opcode`, in, 1: control unit decoded an invalid opcode.
- `req_ovf`, in, 1: ALU overflow in an architecturally checked state (already qualified by the control unit).
- `req_div0`, in, 1: divide with zero divisor.
- `busy`, out, 1: exception sequence active; the control unit must freeze its state and drive no writes.
- `epc_write`, out, 1: load EPC from the ALU result.
- `alu_ovr`, out, 1: ALU select override enable.
- `alu_srca`, out, 1: ALUSrcA value while overriding; 0 selects PC.
- `alu_srcb`, out, 2: ALUSrcB value while overriding; 2'b01 selects the constant 4.
- `alu_op`, out, 3: ULAOp while overriding; 3'b010 is SUB.
- `addr_ovr`, out, 1: memory address override. While high, Address = `vec_addr` and memory Wr is forced to 0.
- `vec_addr`, out, 32: vector table address.
- `pc_load`, out, 1: PC load strobe.
- `pc_src`, out, 2: PCSource value while `pc_load` is high; 2'b11 selects the extended memory byte.
- `cause`, out, 2: last exception cause. 01 = opcode, 10 = overflow, 11 = div0, 00 = none.

## Operation

States: `IDLE`, `SAVE_EPC`, `VEC_RD`, `PC_LD`.
- **`IDLE`**
  - All outputs 0 except `cause`, which holds its value.
  - If any request is high, latch the winning cause and go to `SAVE_EPC`.
  - Priority: `req_opcode` > `req_ovf` > `req_div0`.
  - `cause` updates on the same edge as the transition.
- **`SAVE_EPC`** (1 cycle)
  - Drives `alu_ovr`=1, `alu_srca`=0, `alu_srcb`=2'b01, `alu_op`=3'b010, `epc_write`=1.
  - EPC captures PC−4 at the end of this cycle.
  - Next state: `VEC_RD`.
- **`VEC_RD`** (`MEM_LAT` cycles)
  - Drives `addr_ovr`=1 and `vec_addr` = the vector for the latched cause.
  - A down-counter loaded with `MEM_LAT`−1 on entry decides when to leave.
  - Next state: `PC_LD`.
- **`PC_LD`** (1 cycle)
  - Keeps `addr_ovr` and `vec_addr` stable.
  - Drives `pc_load`=1, `pc_src`=2'b11.
  - PC captures the zero-extended byte.
  - Next state: `IDLE`.
- **`busy`** = (state != `IDLE`). It is registered-state decode with no combinational path from the request inputs.
- **Override defaults:** when the override outputs are inactive they drive 0 (`alu_srca`, `alu_srcb`, `alu_op`, `pc_src`, `vec_addr` = 0).

## Timing

- Reset values:
  - state = `IDLE`
  - `cause` = 2'b00
  - counter = 0
  - every output = 0
- Latency:
  - Request is sampled high at edge N; `busy` rises after edge N.
  - `pc_load` is high in cycle N+1+`MEM_LAT`.
  - `busy` falls after edge N+2+`MEM_LAT`.
  - Total busy length is `MEM_LAT`+2 cycles (3 with the default).
- Requests are sampled only in `IDLE`. Requests during `busy` are ignored, not queued. A request still high in the first `IDLE` cycle after a sequence starts a new sequence.
- When requests arrive simultaneously, only the highest-priority one is taken; the lower ones are dropped.
- If `reset_l` falls mid-sequence, all outputs drop to 0 asynchronously with no partial PC load. Any EPC value already written stays.
- `vec_addr` is stable for the whole `VEC_RD` + `PC_LD` window. It never changes while `addr_ovr` = 1.

## Structure

- Shared package `exc_pkg`:
  - state enum `exc_state_t`
  - cause codes `CAUSE_NONE`, `CAUSE_OPC`, `CAUSE_OVF`, `CAUSE_DIV0`
  - ULA constant `ULA_SUB` = 3'b010
  - mux select constants `SRCB_FOUR` = 2'b01 and `PCSRC_MEMEXT` = 2'b11
- Single module, no sub-module. The latency counter is a 2-bit local register.

## Test plan

- **Overflow, default latency:** `req_ovf` pulsed 1 cycle in `IDLE`, PC = 0x40 →
  - `busy` for 3 cycles;
  - `epc_write` in cycle 1 with ALU = 0x3C;
  - `vec_addr` = 254 in cycles 2–3;
  - `pc_load` in cycle 3;
  - `cause` = 2'b10.
- **Simultaneous requests:** `req_opcode`, `req_ovf` and `req_div0` all high together → `cause` = 01, `vec_addr` = 253, exactly one sequence.
- **Request during busy:** `req_div0` asserted in the `SAVE_EPC` cycle of an opcode sequence and deasserted before `IDLE` → no second sequence; `cause` stays 01.
- **Longer memory latency:** `MEM_LAT` = 3 with `req_div0` → `addr_ovr` high for 4 cycles (3 in `VEC_RD` plus `PC_LD`), `vec_addr` = 255 constant, `busy` = 5 cycles, `pc_load` only in the last cycle.
- **Reset mid-sequence:** `reset_l` low during `VEC_RD` → all outputs 0 immediately, `cause` = 00, no `pc_load`; after release, `IDLE` accepts a new `req_ovf` normally.
- **Held request:** `req_opcode` held high continuously → back-to-back sequences separated by exactly one `IDLE` cycle with `busy` = 0.
